bp_fpga_host_nbf_deserializer: RTL

- Sits between the UART receiver byte stream and the FPGA host io_in path.
- Assembles 8-bit bytes arriving from the PC host into complete NBF packets of {opcode, addr, data} and presents them on a valid/ready-and interface.
- Discards partial packets on a framing error or an inter-byte timeout, so the host resynchronises cleanly after line glitches or an aborted transfer.

---
 rtl/bp_fpga_host_nbf_deserializer.sv | 75 +++++++
 1 files changed

// File: rtl/bp_fpga_host_nbf_deserializer.sv
// bp_fpga_host_nbf_deserializer: assembles UART bytes into NBF packets, dropping partials on error/timeout
`timescale 1ns/1ps
module bp_fpga_host_nbf_deserializer #(
  parameter int nbf_addr_width_p   = 40,
  parameter int nbf_data_width_p   = 64,
  parameter int nbf_opcode_width_p = 8,
  parameter int timeout_cycles_p   = 1000000,
  localparam int nbf_width_lp = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p
)(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [7:0]              byte_i,
  input  logic                    byte_v_i,
  input  logic                    byte_err_i,
  output logic                    byte_ready_and_o,
  output logic [nbf_width_lp-1:0] nbf_o,
  output logic                    nbf_v_o,
  input  logic                    nbf_ready_and_i,
  output logic [7:0]              drop_count_o,
  output logic                    error_o
);
  localparam int nbf_bytes_lp = nbf_width_lp / 8;
  localparam int cw_lp = $clog2(nbf_bytes_lp);
  localparam int tw_lp = $clog2(timeout_cycles_p);
  localparam logic [cw_lp-1:0] last_lp = cw_lp'(nbf_bytes_lp - 1);
  localparam logic [tw_lp-1:0] tmax_lp = tw_lp'(timeout_cycles_p - 1);
  logic [cw_lp-1:0] cnt_q, cnt_d;
  logic [tw_lp-1:0] timer_q, timer_d;
  logic [nbf_width_lp-1:0] asm_q, asm_d, nbf_q, nbf_d;
  logic nbf_v_q, nbf_v_d, err_q, err_d;
  logic [7:0] drop_q, drop_d;
  logic accept, store, final_byte, timeout, drop;
  // Only the final byte can stall: it needs the output register free (or freeing this cycle).
  assign byte_ready_and_o = ~((cnt_q == last_lp) & nbf_v_q & ~nbf_ready_and_i);
  always_comb begin
    accept = byte_v_i & byte_ready_and_o;
    store = accept & ~byte_err_i;
    final_byte = store & (cnt_q == last_lp);
    timeout = ~accept & (cnt_q != '0) & (timer_q == tmax_lp);
    drop = (accept & byte_err_i) | timeout;
    asm_d = asm_q;
    if (store) asm_d[8*cnt_q +: 8] = byte_i;
    cnt_d = (drop | final_byte) ? '0 : store ? cnt_q + 1'b1 : cnt_q;
    timer_d = (accept | drop | (cnt_q == '0)) ? '0 : timer_q + 1'b1;
    nbf_v_d = final_byte | (nbf_v_q & ~nbf_ready_and_i);
    nbf_d = final_byte ? {asm_d[0 +: nbf_opcode_width_p],
                          asm_d[nbf_opcode_width_p +: nbf_addr_width_p],
                          asm_d[nbf_width_lp-1 -: nbf_data_width_p]} : nbf_q;
    drop_d = (drop & (drop_q != 8'hff)) ? drop_q + 8'd1 : drop_q;
    err_d = err_q | drop;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      timer_q <= '0;
      asm_q   <= '0;
      nbf_q   <= '0;
      nbf_v_q <= 1'b0;
      drop_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      asm_q   <= asm_d;
      nbf_q   <= nbf_d;
      nbf_v_q <= nbf_v_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end
  assign nbf_o = nbf_q;
  assign nbf_v_o = nbf_v_q;
  assign drop_count_o = drop_q;
  assign error_o = err_q;
endmodule
